// File: rtl/genvar_lane_tx.sv
// Parallel-to-serial lane transmitter: captures a LANES-wide word into per-lane
// registers, then streams the lanes out one beat at a time with a constant bias added.
module genvar_lane_tx #(
  parameter  int LANES = 2,
  parameter  int WIDTH = 32,
  parameter  int BIAS  = 0,
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IW-1:0]          out_lane,
  output logic                   out_last
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [IW-1:0]    LAST_IDX = IW'(LANES - 1);
  localparam logic [WIDTH-1:0] BIAS_W   = WIDTH'(BIAS);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_next;
  logic [LANES*WIDTH-1:0] w_lanes;
  logic [WIDTH-1:0]       w_sel;
  logic                   w_accept;
  logic                   w_is_last;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_is_last = (r_idx == LAST_IDX);

  // Each lane owns its register; they only load on the accept edge of IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] r_val;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_val <= '0;
        end else if (w_accept) begin
          r_val <= in_data[gi*WIDTH +: WIDTH];
        end
      end

      assign w_lanes[gi*WIDTH +: WIDTH] = r_val;
    end
  endgenerate

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel = w_lanes[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = S_SEND;
          w_idx_next   = '0;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (w_is_last) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Outputs depend only on registered state; beat fields read as zero when idle.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_SEND);
  assign out_data  = out_valid ? (w_sel + BIAS_W) : '0;
  assign out_lane  = out_valid ? r_idx : '0;
  assign out_last  = out_valid & w_is_last;

endmodule

// File: tb/tb_genvar_lane_tx.sv
// Bench for genvar_lane_tx: a queue-of-beats model on a randomized instance plus
// directed scenarios on small instances with other parameter sets.
module tb_genvar_lane_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instance A: LANES=2, BIAS=9001, model-checked every cycle
  localparam int A_BIAS = 9001;
  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [63:0] a_in_data;
  logic [31:0] a_out_data;
  logic [0:0]  a_out_lane;

  genvar_lane_tx #(.LANES(2), .WIDTH(32), .BIAS(A_BIAS)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_lane(a_out_lane), .out_last(a_out_last));

  // Instance B: LANES=2, BIAS=0
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [63:0] b_in_data;
  logic [31:0] b_out_data;
  logic [0:0]  b_out_lane;

  genvar_lane_tx #(.LANES(2), .WIDTH(32), .BIAS(0)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_lane(b_out_lane), .out_last(b_out_last));

  // Instance C: LANES=2, BIAS=1 (wrap)
  logic        c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [63:0] c_in_data;
  logic [31:0] c_out_data;
  logic [0:0]  c_out_lane;

  genvar_lane_tx #(.LANES(2), .WIDTH(32), .BIAS(1)) u_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_lane(c_out_lane), .out_last(c_out_last));

  // Instance D: LANES=1, BIAS=0
  logic        d_rst, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last;
  logic [31:0] d_in_data;
  logic [31:0] d_out_data;
  logic [0:0]  d_out_lane;

  genvar_lane_tx #(.LANES(1), .WIDTH(32), .BIAS(0)) u_d (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_lane(d_out_lane), .out_last(d_out_last));

  // Reference model for A: the list of beats still owed to the consumer.
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        last;
  } beat_t;

  beat_t q_a[$];
  logic  a_live = 1'b0;

  always @(posedge clk) begin
    if (a_rst) begin
      q_a.delete();
      a_live <= 1'b1;
    end else if (q_a.size() == 0) begin
      if (a_in_valid) begin
        for (int i = 0; i < 2; i++) begin
          q_a.push_back('{d: a_in_data[i*32 +: 32] + 32'(A_BIAS), l: i[0], last: (i == 1)});
        end
      end
    end else if (a_out_ready) begin
      void'(q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (a_live) begin
      if (q_a.size() == 0) begin
        chk("a_in_ready",  64'(a_in_ready),  64'd1);
        chk("a_out_valid", 64'(a_out_valid), 64'd0);
        chk("a_out_data",  64'(a_out_data),  64'd0);
        chk("a_out_lane",  64'(a_out_lane),  64'd0);
        chk("a_out_last",  64'(a_out_last),  64'd0);
      end else begin
        chk("a_in_ready",  64'(a_in_ready),  64'd0);
        chk("a_out_valid", 64'(a_out_valid), 64'd1);
        chk("a_out_data",  64'(a_out_data),  64'(q_a[0].d));
        chk("a_out_lane",  64'(a_out_lane),  64'(q_a[0].l));
        chk("a_out_last",  64'(a_out_last),  64'(q_a[0].last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic v, input logic [31:0] d,
                       input logic l, input logic last, input logic rdy);
    chk({nm, "_valid"}, 64'(b_out_valid), 64'(v));
    chk({nm, "_data"},  64'(b_out_data),  64'(d));
    chk({nm, "_lane"},  64'(b_out_lane),  64'(l));
    chk({nm, "_last"},  64'(b_out_last),  64'(last));
    chk({nm, "_ready"}, 64'(b_in_ready),  64'(rdy));
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1; d_rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0; d_out_ready = 1'b0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0; d_in_data = '0;
    repeat (2) tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;

    // Reset state
    chk_b("b_reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("d_reset_ready", 64'(d_in_ready), 64'd1);
    chk("d_reset_valid", 64'(d_out_valid), 64'd0);

    // B: basic two-beat frame
    b_in_data = {32'd1, 32'd0}; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk_b("b_beat0", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_b("b_beat1", 1'b1, 32'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_b("b_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // B: stall on lane1, a new word offered during the stall must be ignored
    b_in_data = {32'hBB, 32'hAA}; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk_b("b_st0", 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    tick();
    chk_b("b_st1", 1'b1, 32'hBB, 1'b1, 1'b1, 1'b0);
    b_out_ready = 1'b0;
    b_in_data = {32'h22, 32'h11}; b_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_b("b_stall", 1'b1, 32'hBB, 1'b1, 1'b1, 1'b0);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    chk_b("b_release", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_b("b_nocapture", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // B: reset one cycle after the lane0 beat abandons lane1
    b_in_data = {32'h66, 32'h55}; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk_b("b_pre_rst", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk_b("b_rst_mid", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_b("b_rst_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // B: reset and in_valid together, reset wins
    b_rst = 1'b1; b_in_valid = 1'b1; b_in_data = {32'h77, 32'h88};
    tick();
    b_rst = 1'b0; b_in_valid = 1'b0;
    chk_b("b_rst_vs_valid", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // C: bias wraps modulo 2^32
    c_in_data = {32'd5, 32'hFFFF_FFFF}; c_in_valid = 1'b1; c_out_ready = 1'b1;
    tick();
    c_in_valid = 1'b0;
    chk("c_wrap_data",  64'(c_out_data),  64'd0);
    chk("c_wrap_lane",  64'(c_out_lane),  64'd0);
    chk("c_wrap_valid", 64'(c_out_valid), 64'd1);
    tick();
    chk("c_l1_data", 64'(c_out_data), 64'd6);
    chk("c_l1_last", 64'(c_out_last), 64'd1);

    // D: single lane, two words back-to-back land two cycles apart
    d_in_data = 32'd7; d_in_valid = 1'b1; d_out_ready = 1'b1;
    tick();
    chk("d_w0_data",  64'(d_out_data),  64'd7);
    chk("d_w0_last",  64'(d_out_last),  64'd1);
    chk("d_w0_lane",  64'(d_out_lane),  64'd0);
    chk("d_w0_ready", 64'(d_in_ready),  64'd0);
    tick();
    chk("d_gap_valid", 64'(d_out_valid), 64'd0);
    chk("d_gap_ready", 64'(d_in_ready),  64'd1);
    tick();
    d_in_valid = 1'b0;
    chk("d_w1_data",  64'(d_out_data),  64'd7);
    chk("d_w1_last",  64'(d_out_last),  64'd1);
    tick();
    chk("d_end_valid", 64'(d_out_valid), 64'd0);

    // A: literal pins for the model (42 + 9001, 0 + 9001)
    a_in_data = {32'd0, 32'd42}; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("a_pin0_dut",   64'(a_out_data), 64'd9043);
    chk("a_pin0_model", 64'(q_a[0].d),   64'd9043);
    tick();
    chk("a_pin1_dut",   64'(a_out_data), 64'd9001);
    chk("a_pin1_model", 64'(q_a[0].d),   64'd9001);
    tick();

    // A: randomized traffic, backpressure and occasional resets
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (q_a.size() == 0 || !a_in_valid) begin
        a_in_valid = ($urandom_range(0, 2) != 0);
        a_in_data  = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a_in_data[31:0] = 32'hFFFF_DCD7;
        if ($urandom_range(0, 3) == 0) a_in_data[63:32] = 32'hFFFF_FFFF;
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_rst       = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    a_rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
